act_row_feeder: RTL and testbench
=================================

ACT_ROW_FEEDER -- requirements
Module: act_row_feeder

Interface
REQ-001 Parameter N_ROW, default 30: number of superblock rows fed.
REQ-002 Parameter WID_ACT, default 16: activation element width; one transfer carries 2*WID_ACT bits.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2: per-row buffer entries.
REQ-004 Parameter WID_ROW, default $clog2(N_ROW): row-index width.
REQ-005 clk_l  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 s_data  input  2*WID_ACT  activation pair from the controller stream.
REQ-008 s_row  input  WID_ROW  destination row index.
REQ-009 s_bcast  input  1  when high, write the pair to every row; s_row is ignored.
REQ-010 s_vld  input  1  s_data, s_row and s_bcast are valid.
REQ-011 s_rdy  output  1  feeder accepts the current beat.
REQ-012 flush  input  1  synchronous clear of all row buffers.
REQ-013 act_data_in  output  2*WID_ACT*N_ROW  row r head at bits [r*2*WID_ACT +: 2*WID_ACT].
REQ-014 act_data_in_vld  output  N_ROW  row r head is valid.
REQ-015 act_data_in_req  input  N_ROW  row r consumes its head.
REQ-016 row_empty  output  N_ROW  row r buffer empty.
REQ-017 err_row  output  1  sticky: a beat addressed an out-of-range row.

Function
REQ-018 An input beat is accepted in the cycle where s_vld and s_rdy are both high.
REQ-019 s_rdy is high when the addressed row is not full, or when s_bcast is high and no row is full, or when s_row >= N_ROW; it does not depend on act_data_in_req, and it is low while flush is high.
REQ-020 An accepted unicast beat is pushed into row s_row; an accepted broadcast beat is pushed into all N_ROW rows in the same cycle.
REQ-021 An accepted beat with s_row >= N_ROW and s_bcast low is dropped without a push, and err_row is set to 1 until reset.
REQ-022 A row output transfer occurs in a cycle where act_data_in_req[r] and act_data_in_vld[r] are both high; the head entry is popped on that edge.
REQ-023 Each row buffer is show-ahead: act_data_in_vld[r] = !row_empty[r], and act_data_in for that row carries the head entry combinationally from the buffer registers.
REQ-024 Latency: a beat accepted at edge t is visible on act_data_in_vld at t+1.
REQ-025 Simultaneous push and pop on the same row keep occupancy unchanged and preserve order; a push into a full row cannot occur (REQ-019).
REQ-026 act_data_in_req[r] while row r is empty has no effect.
REQ-027 Per row, read and write pointers are WID=$clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full means the MSBs differ and the low bits are equal; empty means the pointers are equal.
REQ-028 flush high empties every row on the next edge, wins over any simultaneous push or pop, and leaves err_row unchanged.
REQ-029 Entries leave each row in strict FIFO order; rows are independent of each other apart from the broadcast rule.

Reset
REQ-030 While rst_n is low, all pointers are 0, row_empty is all ones, act_data_in_vld is 0, s_rdy is 0, and err_row is 0.
REQ-031 The buffer data storage is not reset; act_data_in is don't-care while act_data_in_vld is low.
REQ-032 Reset asserted mid-operation discards all buffered data immediately; s_rdy rises on the first edge after rst_n deasserts.

Structure
REQ-033 A shared package sblk_pkg holds the default N_ROW and WID_ACT constants and the act_pair_t typedef (2*WID_ACT bits), which act_row_feeder and the superblock row share.
REQ-034 A single sub-module act_fifo (show-ahead, parameterised by width and depth, with a flush input) is instantiated N_ROW times in a generate loop; the top level holds only the s_rdy and push-decode logic and err_row.

Verification
REQ-035 Scenario 1: unicast 0xAAAA_0001 to row 3 with all req low -> act_data_in_vld = 1 only for row 3 one cycle later, with the data slice matching; raise req[3] for one cycle -> row 3 empty.
REQ-036 Scenario 2: push FIFO_DEPTH=4 beats to row 0 with req[0] low -> after the 4th beat s_rdy = 0 for s_row=0 and stays 1 for s_row=1; pulse req[0] -> s_rdy returns to 1 on the next cycle.
REQ-037 Scenario 3: broadcast 0x1234_5678 with row 7 full -> s_rdy = 0 and no row changes; drain row 7 by one entry -> the beat is accepted and all 30 rows gain the entry.
REQ-038 Scenario 4: s_row=31 with N_ROW=30 -> beat accepted, no row changes, err_row = 1 and stays 1 after flush.
REQ-039 Scenario 5: row 5 holding 2 entries, with push and req[5] in the same cycle -> occupancy stays 2 and output order is preserved over 8 random push/pop cycles.
REQ-040 Scenario 6: flush or rst_n low with 3 entries in several rows -> all act_data_in_vld are 0 on the next edge (immediately for rst_n), and s_rdy rules are restored afterwards.

Source files
------------

// File: rtl/sblk_pkg.sv
// Constants and types shared by the activation row feeder and the superblock rows.
package sblk_pkg;

  localparam int SBLK_N_ROW   = 30;
  localparam int SBLK_WID_ACT = 16;

  typedef logic [2*SBLK_WID_ACT-1:0] act_pair_t;

endpackage

// File: rtl/act_fifo.sv
// Show-ahead FIFO with extra-MSB pointers; the head is read combinationally from storage.
module act_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_l,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  // Status flags, gated push/pop strobes and the show-ahead head entry.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_push_s = push && !full && !flush;
    do_pop_s  = pop && !empty && !flush;
    head      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer update; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk_l) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/act_row_feeder.sv
// Distributes controller activation pairs into per-row show-ahead buffers (unicast or broadcast).
module act_row_feeder
  import sblk_pkg::*;
#(
  parameter int N_ROW      = SBLK_N_ROW,
  parameter int WID_ACT    = SBLK_WID_ACT,
  parameter int FIFO_DEPTH = 4,
  parameter int WID_ROW    = $clog2(N_ROW)
) (
  input  logic                       clk_l,
  input  logic                       rst_n,
  input  logic [2*WID_ACT-1:0]       s_data,
  input  logic [WID_ROW-1:0]         s_row,
  input  logic                       s_bcast,
  input  logic                       s_vld,
  output logic                       s_rdy,
  input  logic                       flush,
  output logic [2*WID_ACT*N_ROW-1:0] act_data_in,
  output logic [N_ROW-1:0]           act_data_in_vld,
  input  logic [N_ROW-1:0]           act_data_in_req,
  output logic [N_ROW-1:0]           row_empty,
  output logic                       err_row
);

  localparam int DW = 2 * WID_ACT;

  logic [N_ROW-1:0] hit_s;
  logic [N_ROW-1:0] push_s;
  logic [N_ROW-1:0] empty_s;
  logic [N_ROW-1:0] full_s;
  logic             oob_s;
  logic             accept_s;
  logic             rdy_en_r;
  logic             err_row_r;

  // Row decode, ready qualification and push fan-out; broadcast ignores s_row entirely.
  always_comb begin
    hit_s = {N_ROW{1'b0}};
    for (int r = 0; r < N_ROW; r++) begin
      hit_s[r] = (s_row == WID_ROW'(r));
    end
    oob_s = ({1'b0, s_row} >= (WID_ROW + 1)'(N_ROW));
    if (!rdy_en_r || flush) begin
      s_rdy = 1'b0;
    end else if (s_bcast) begin
      s_rdy = ~(|full_s);
    end else if (oob_s) begin
      s_rdy = 1'b1;
    end else begin
      s_rdy = ~(|(hit_s & full_s));
    end
    accept_s = s_vld && s_rdy;
    if (!accept_s) begin
      push_s = {N_ROW{1'b0}};
    end else if (s_bcast) begin
      push_s = {N_ROW{1'b1}};
    end else begin
      push_s = hit_s;
    end
  end

  // Ready enable rises on the first edge out of reset; err_row is sticky until reset.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_r  <= 1'b0;
      err_row_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      if (accept_s && !s_bcast && oob_s) err_row_r <= 1'b1;
    end
  end

  assign err_row         = err_row_r;
  assign row_empty       = empty_s;
  assign act_data_in_vld = ~empty_s;

  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    act_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_l     (clk_l),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push_s[r]),
      .push_data (s_data),
      .pop       (act_data_in_req[r]),
      .head      (act_data_in[r*DW +: DW]),
      .empty     (empty_s[r]),
      .full      (full_s[r])
    );
  end

endmodule

// File: tb/tb_act_row_feeder.sv
// Scoreboard bench for act_row_feeder: per-row expected queues filled on accepted beats.
module tb_act_row_feeder;

  localparam int N  = 30;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int WR = 5;
  localparam int DW = 2 * W;

  logic              clk_l = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     s_data;
  logic [WR-1:0]     s_row;
  logic              s_bcast;
  logic              s_vld;
  logic              s_rdy;
  logic              flush;
  logic [DW*N-1:0]   act_data_in;
  logic [N-1:0]      act_data_in_vld;
  logic [N-1:0]      req;
  logic [N-1:0]      row_empty;
  logic              err_row;

  logic [DW-1:0] model_q [N][$];
  logic [DW-1:0] exp_pop_q [$];
  logic [DW-1:0] got_pop_q [$];
  logic          err_model;
  logic          rdy_en_m;
  int            checks;
  int            errors;

  act_row_feeder #(.N_ROW(N), .WID_ACT(W), .FIFO_DEPTH(D), .WID_ROW(WR)) dut (
    .clk_l           (clk_l),
    .rst_n           (rst_n),
    .s_data          (s_data),
    .s_row           (s_row),
    .s_bcast         (s_bcast),
    .s_vld           (s_vld),
    .s_rdy           (s_rdy),
    .flush           (flush),
    .act_data_in     (act_data_in),
    .act_data_in_vld (act_data_in_vld),
    .act_data_in_req (req),
    .row_empty       (row_empty),
    .err_row         (err_row)
  );

  always #5 clk_l = ~clk_l;

  function automatic logic model_rdy();
    logic ok;
    if (!rst_n || !rdy_en_m || flush) return 1'b0;
    if (s_bcast) begin
      ok = 1'b1;
      for (int r = 0; r < N; r++) if (model_q[r].size() >= D) ok = 1'b0;
      return ok;
    end
    if (int'(s_row) >= N) return 1'b1;
    return model_q[s_row].size() < D;
  endfunction

  function automatic logic [N-1:0] model_vld();
    logic [N-1:0] v;
    for (int r = 0; r < N; r++) v[r] = (model_q[r].size() != 0);
    return v;
  endfunction

  // Advance one clock, applying the reference behaviour for the inputs currently driven.
  task automatic tick();
    logic acc;
    acc = s_vld && model_rdy();
    if (!rst_n || flush) begin
      for (int r = 0; r < N; r++) model_q[r].delete();
    end else begin
      for (int r = 0; r < N; r++) begin
        if (req[r] && model_q[r].size() != 0) begin
          exp_pop_q.push_back(model_q[r].pop_front());
          got_pop_q.push_back(act_data_in[r*DW +: DW]);
        end
      end
      if (acc) begin
        if (s_bcast) for (int r = 0; r < N; r++) model_q[r].push_back(s_data);
        else if (int'(s_row) >= N) err_model = 1'b1;
        else model_q[s_row].push_back(s_data);
      end
    end
    @(posedge clk_l);
    #1;
    rdy_en_m = rst_n;
  endtask

  task automatic push_beat(input int row, input logic [DW-1:0] d);
    s_vld = 1'b1; s_bcast = 1'b0; s_row = WR'(row); s_data = d;
    tick();
    s_vld = 1'b0;
  endtask

  task automatic drain_all();
    req = {N{1'b1}};
    repeat (D) tick();
    req = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_vld = 1'b0; s_bcast = 1'b0; s_row = '0; s_data = '0; flush = 1'b0; req = '0;
    err_model = 1'b0; rdy_en_m = 1'b0;
    repeat (2) tick();
    checks++;
    if (act_data_in_vld !== '0 || row_empty !== {N{1'b1}} || s_rdy !== 1'b0 || err_row !== 1'b0) begin
      errors++;
      $display("FAIL reset_state vld=%h empty=%h rdy=%b err=%b", act_data_in_vld, row_empty, s_rdy, err_row);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_rdy !== 1'b0) begin errors++; $display("FAIL rdy_before_edge got=%b exp=0", s_rdy); end
    tick();
    checks++;
    if (s_rdy !== model_rdy()) begin errors++; $display("FAIL rdy_after_release got=%b exp=%b", s_rdy, model_rdy()); end
  endtask

  task automatic test_unicast();
    logic [DW-1:0] e, g;
    push_beat(3, 32'hAAAA_0001);
    checks++;
    if (act_data_in_vld !== model_vld()) begin errors++; $display("FAIL uni_vld got=%h exp=%h", act_data_in_vld, model_vld()); end
    checks++;
    if (act_data_in[3*DW +: DW] !== model_q[3][0]) begin
      errors++; $display("FAIL uni_data got=%h exp=%h", act_data_in[3*DW +: DW], model_q[3][0]);
    end
    req[3] = 1'b1; tick(); req = '0;
    checks++;
    if (row_empty[3] !== 1'b1) begin errors++; $display("FAIL uni_empty got=%b exp=1", row_empty[3]); end
    while (exp_pop_q.size() != 0) begin
      e = exp_pop_q.pop_front(); g = got_pop_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL uni_pop got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] e, g;
    for (int i = 0; i < D; i++) push_beat(0, 32'h0000_0100 + DW'(i));
    s_row = 5'd0; #1;
    checks++;
    if (s_rdy !== model_rdy() || s_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_row0 got=%b exp=0", s_rdy); end
    s_row = 5'd1; #1;
    checks++;
    if (s_rdy !== model_rdy()) begin errors++; $display("FAIL full_rdy_row1 got=%b exp=%b", s_rdy, model_rdy()); end
    s_row = 5'd0; req[0] = 1'b1; tick(); req = '0;
    checks++;
    if (s_rdy !== model_rdy()) begin errors++; $display("FAIL full_rdy_after_pop got=%b exp=%b", s_rdy, model_rdy()); end
    drain_all();
    while (exp_pop_q.size() != 0) begin
      e = exp_pop_q.pop_front(); g = got_pop_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL full_pop got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_bcast();
    logic [DW-1:0] e, g;
    for (int i = 0; i < D; i++) push_beat(7, 32'h0000_0700 + DW'(i));
    s_vld = 1'b1; s_bcast = 1'b1; s_row = 5'd7; s_data = 32'h1234_5678; #1;
    checks++;
    if (s_rdy !== 1'b0) begin errors++; $display("FAIL bcast_blocked got=%b exp=0", s_rdy); end
    tick();
    checks++;
    if (act_data_in_vld !== model_vld()) begin errors++; $display("FAIL bcast_nochange got=%h exp=%h", act_data_in_vld, model_vld()); end
    req[7] = 1'b1; tick(); req = '0;
    tick();
    s_vld = 1'b0; s_bcast = 1'b0;
    checks++;
    if (act_data_in_vld !== {N{1'b1}}) begin errors++; $display("FAIL bcast_all_vld got=%h", act_data_in_vld); end
    for (int r = 0; r < N; r++) begin
      checks++;
      if (act_data_in[r*DW +: DW] !== model_q[r][0]) begin
        errors++; $display("FAIL bcast_head row=%0d got=%h exp=%h", r, act_data_in[r*DW +: DW], model_q[r][0]);
      end
    end
    drain_all();
    while (exp_pop_q.size() != 0) begin
      e = exp_pop_q.pop_front(); g = got_pop_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL bcast_pop got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_oob();
    s_vld = 1'b1; s_bcast = 1'b0; s_row = 5'd31; s_data = 32'hDEAD_BEEF; #1;
    checks++;
    if (s_rdy !== 1'b1) begin errors++; $display("FAIL oob_rdy got=%b exp=1", s_rdy); end
    tick(); s_vld = 1'b0;
    checks++;
    if (err_row !== err_model || act_data_in_vld !== model_vld()) begin
      errors++; $display("FAIL oob_err got=%b exp=%b vld=%h", err_row, err_model, act_data_in_vld);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++;
    if (err_row !== 1'b1) begin errors++; $display("FAIL oob_sticky got=%b exp=1", err_row); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e, g;
    push_beat(5, 32'h5000_0000);
    push_beat(5, 32'h5000_0001);
    for (int i = 0; i < 8; i++) begin
      s_vld = 1'b1; s_bcast = 1'b0; s_row = 5'd5; s_data = DW'($urandom); req[5] = 1'b1;
      tick();
      checks++;
      if (act_data_in[5*DW +: DW] !== model_q[5][0]) begin
        errors++; $display("FAIL b2b_head cyc=%0d got=%h exp=%h", i, act_data_in[5*DW +: DW], model_q[5][0]);
      end
    end
    s_vld = 1'b0;
    repeat (2) tick();
    req = '0;
    checks++;
    if (row_empty[5] !== 1'b1 || model_q[5].size() != 0) begin errors++; $display("FAIL b2b_occupancy empty=%b exp=1", row_empty[5]); end
    while (exp_pop_q.size() != 0) begin
      e = exp_pop_q.pop_front(); g = got_pop_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_pop got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) begin
      push_beat(1, DW'(i)); push_beat(2, DW'(i + 16)); push_beat(9, DW'(i + 32));
    end
    flush = 1'b1; s_vld = 1'b1; s_row = 5'd1; req[2] = 1'b1; #1;
    checks++;
    if (s_rdy !== 1'b0) begin errors++; $display("FAIL flush_rdy got=%b exp=0", s_rdy); end
    tick(); flush = 1'b0; s_vld = 1'b0; req = '0;
    checks++;
    if (act_data_in_vld !== '0 || exp_pop_q.size() != 0) begin errors++; $display("FAIL flush_vld got=%h exp=0", act_data_in_vld); end
    for (int i = 0; i < 3; i++) begin
      push_beat(1, DW'(i)); push_beat(4, DW'(i + 48));
    end
    #2; rst_n = 1'b0; #1;
    for (int r = 0; r < N; r++) model_q[r].delete();
    rdy_en_m = 1'b0;
    checks++;
    if (act_data_in_vld !== '0 || s_rdy !== 1'b0) begin errors++; $display("FAIL reset_mid vld=%h rdy=%b exp 0/0", act_data_in_vld, s_rdy); end
    checks++;
    if (err_row !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_row); end
    err_model = 1'b0;
    tick(); rst_n = 1'b1; s_row = 5'd1; tick();
    checks++;
    if (s_rdy !== model_rdy()) begin errors++; $display("FAIL reset_rdy_restored got=%b exp=%b", s_rdy, model_rdy()); end
    push_beat(4, 32'hCAFE_0004);
    checks++;
    if (act_data_in_vld !== model_vld() || act_data_in[4*DW +: DW] !== 32'hCAFE_0004) begin
      errors++; $display("FAIL reset_post_push vld=%h exp=%h data=%h", act_data_in_vld, model_vld(), act_data_in[4*DW +: DW]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unicast();
    test_full();
    test_bcast();
    test_oob();
    test_back_to_back();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
